// File: rtl/inst_queue_dual.sv
// rtl/inst_queue_dual.sv - dual-entry push/pop instruction queue between fetch and decode
// Optional same-cycle bypass into an empty queue with macro IQ_BYPASS_EN.
module inst_queue_dual #(
    parameter int INST_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic [1:0]                 push_cnt_in,
    input  logic [INST_W-1:0]          inst0_in,
    input  logic [ADDR_W-1:0]          pc0_in,
    input  logic [INST_W-1:0]          inst1_in,
    input  logic [ADDR_W-1:0]          pc1_in,
    output logic                       full_out,
    input  logic [1:0]                 pop_cnt_in,
    output logic [INST_W-1:0]          inst0_out,
    output logic [ADDR_W-1:0]          pc0_out,
    output logic                       vld0_out,
    output logic [INST_W-1:0]          inst1_out,
    output logic [ADDR_W-1:0]          pc1_out,
    output logic                       vld1_out,
    output logic [$clog2(DEPTH):0]     count_out,
    output logic                       ovf_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C    = CNT_W'(2);
    localparam logic [31:0]      FULL_THR = 32'(2 + FULL_MARGIN);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic [CNT_W-1:0] push_req;
    logic [CNT_W-1:0] pop_req;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] push_acc;
    logic [CNT_W-1:0] pop_acc;
    logic             push_ovf;
    logic             active;
    logic             we0;
    logic             we1;
    logic [PTR_W-1:0] wr1_ptr;
    logic [PTR_W-1:0] rd1_ptr;
    logic             byp_act;

    // Encoding 3 on either count input behaves as 2.
    assign push_req   = (push_cnt_in == 2'd3) ? TWO_C : CNT_W'(push_cnt_in);
    assign pop_req    = (pop_cnt_in  == 2'd3) ? TWO_C : CNT_W'(pop_cnt_in);
    assign free_slots = DEPTH_C - count_q;
    assign push_ovf   = push_req > free_slots;
    assign push_acc   = push_ovf ? free_slots : push_req;
    assign active     = rdy_in && !flush_in;
    assign wr1_ptr    = tail_q + PTR_W'(1);
    assign rd1_ptr    = head_q + PTR_W'(1);

`ifdef IQ_BYPASS_EN
    assign byp_act = active && (count_q == '0);
`else
    assign byp_act = 1'b0;
`endif

    // In bypass the decoder may consume entries that never land in storage.
    always_comb begin
        pop_acc = (pop_req > count_q) ? count_q : pop_req;
        if (byp_act) begin
            pop_acc = (pop_req > push_acc) ? push_acc : pop_req;
        end
    end

    // Pushed entries sit at tail/tail+1 even when a bypassed older one was popped.
    always_comb begin
        we0 = active && (push_acc >= ONE_C);
        we1 = active && (push_acc >= TWO_C);
        if (byp_act) begin
            we0 = we0 && (pop_acc < ONE_C);
            we1 = we1 && (pop_acc < TWO_C);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + PTR_W'(pop_acc);
                tail_q  <= tail_q + PTR_W'(push_acc);
                count_q <= count_q + push_acc - pop_acc;
                if (push_ovf) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (we0) begin
            inst_mem[tail_q] <= inst0_in;
            pc_mem[tail_q]   <= pc0_in;
        end
        if (we1) begin
            inst_mem[wr1_ptr] <= inst1_in;
            pc_mem[wr1_ptr]   <= pc1_in;
        end
    end

    always_comb begin
        vld0_out  = count_q >= ONE_C;
        vld1_out  = count_q >= TWO_C;
        inst0_out = inst_mem[head_q];
        pc0_out   = pc_mem[head_q];
        inst1_out = inst_mem[rd1_ptr];
        pc1_out   = pc_mem[rd1_ptr];
        if (byp_act) begin
            vld0_out  = push_req >= ONE_C;
            vld1_out  = push_req >= TWO_C;
            inst0_out = inst0_in;
            pc0_out   = pc0_in;
            inst1_out = inst1_in;
            pc1_out   = pc1_in;
        end
    end

    assign count_out = count_q;
    assign full_out  = 32'(free_slots) < FULL_THR;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_inst_queue_dual.sv
// tb/tb_inst_queue_dual.sv - randomized bench for inst_queue_dual against a queue-based model
module tb_inst_queue_dual;

    localparam int DEPTH       = 16;
    localparam int FULL_MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [1:0]  push_cnt_in;
    logic [31:0] inst0_in;
    logic [31:0] pc0_in;
    logic [31:0] inst1_in;
    logic [31:0] pc1_in;
    logic        full_out;
    logic [1:0]  pop_cnt_in;
    logic [31:0] inst0_out;
    logic [31:0] pc0_out;
    logic        vld0_out;
    logic [31:0] inst1_out;
    logic [31:0] pc1_out;
    logic        vld1_out;
    logic [4:0]  count_out;
    logic        ovf_out;

    inst_queue_dual #(
        .INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .push_cnt_in(push_cnt_in), .inst0_in(inst0_in), .pc0_in(pc0_in),
        .inst1_in(inst1_in), .pc1_in(pc1_in), .full_out(full_out),
        .pop_cnt_in(pop_cnt_in), .inst0_out(inst0_out), .pc0_out(pc0_out),
        .vld0_out(vld0_out), .inst1_out(inst1_out), .pc1_out(pc1_out),
        .vld1_out(vld1_out), .count_out(count_out), .ovf_out(ovf_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        model_q[$];
    logic        model_ovf;
    int          n_checks;
    int          n_fail;
    logic [31:0] next_pc;
    logic [31:0] saved_pc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp2(input logic [1:0] v);
        return (v == 2'd3) ? 2 : int'(v);
    endfunction

    function automatic logic bypass_now();
        logic b;
        b = 1'b0;
`ifdef IQ_BYPASS_EN
        b = (model_q.size() == 0) && rdy_in && !flush_in;
`endif
        return b;
    endfunction

    task automatic check_outputs();
        int sz;
        int pr;
        sz = model_q.size();
        pr = clamp2(push_cnt_in);
        check_eq("count", 64'(count_out), 64'(sz));
        check_eq("full", 64'(full_out), 64'((DEPTH - sz) < (2 + FULL_MARGIN)));
        check_eq("ovf", 64'(ovf_out), 64'(model_ovf));
        if (bypass_now()) begin
            check_eq("byp_vld0", 64'(vld0_out), 64'(pr >= 1));
            check_eq("byp_vld1", 64'(vld1_out), 64'(pr >= 2));
            if (pr >= 1) check_eq("byp_pc0", 64'(pc0_out), 64'(pc0_in));
            if (pr >= 2) check_eq("byp_pc1", 64'(pc1_out), 64'(pc1_in));
        end else begin
            check_eq("vld0", 64'(vld0_out), 64'(sz >= 1));
            check_eq("vld1", 64'(vld1_out), 64'(sz >= 2));
            if (sz >= 1) begin
                check_eq("pc0", 64'(pc0_out), 64'(model_q[0].pc));
                check_eq("inst0", 64'(inst0_out), 64'(model_q[0].inst));
            end
            if (sz >= 2) begin
                check_eq("pc1", 64'(pc1_out), 64'(model_q[1].pc));
                check_eq("inst1", 64'(inst1_out), 64'(model_q[1].inst));
            end
        end
    endtask

    task automatic model_update();
        int   pr;
        int   po;
        int   free;
        int   pa;
        int   pacc;
        ent_t ent [2];
        if (!rdy_in) return;
        if (flush_in) begin
            model_q.delete();
            return;
        end
        pr     = clamp2(push_cnt_in);
        po     = clamp2(pop_cnt_in);
        free   = DEPTH - model_q.size();
        pa     = (pr < free) ? pr : free;
        if (pr > free) model_ovf = 1'b1;
        ent[0] = {inst0_in, pc0_in};
        ent[1] = {inst1_in, pc1_in};
        if (bypass_now()) begin
            pacc = (po < pa) ? po : pa;
            for (int i = pacc; i < pa; i++) model_q.push_back(ent[i]);
        end else begin
            pacc = (po < model_q.size()) ? po : model_q.size();
            for (int i = 0; i < pacc; i++) void'(model_q.pop_front());
            for (int i = 0; i < pa; i++) model_q.push_back(ent[i]);
        end
    endtask

    task automatic drive(input logic rdy, input logic flush, input int push, input int pop);
        rdy_in      = rdy;
        flush_in    = flush;
        push_cnt_in = 2'(push);
        pop_cnt_in  = 2'(pop);
        pc0_in      = next_pc;
        pc1_in      = next_pc + 32'd4;
        inst0_in    = $urandom;
        inst1_in    = $urandom;
        next_pc     = next_pc + 32'd8;
    endtask

    // Entered at posedge+1; inputs settle, outputs are sampled at the falling edge.
    task automatic step(input logic rdy, input logic flush, input int push, input int pop);
        drive(rdy, flush, push, pop);
        #4;
        check_outputs();
        model_update();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rdy_in      = 1'b0;
        flush_in    = 1'b0;
        push_cnt_in = 2'd0;
        pop_cnt_in  = 2'd0;
        rst_in      = 1'b1;
        #1;
        check_eq("rst_count", 64'(count_out), 64'd0);
        check_eq("rst_vld0", 64'(vld0_out), 64'd0);
        check_eq("rst_vld1", 64'(vld1_out), 64'd0);
        check_eq("rst_full", 64'(full_out), 64'd0);
        check_eq("rst_ovf", 64'(ovf_out), 64'd0);
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        next_pc  = 32'h1000;
        inst0_in = '0;
        inst1_in = '0;
        pc0_in   = '0;
        pc1_in   = '0;
        do_reset();

        // Fill with pairs, then drain and confirm order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2, 0);
        check_eq("fill_count", 64'(count_out), 64'd16);
        check_eq("fill_full", 64'(full_out), 64'd1);
        check_eq("fill_vld1", 64'(vld1_out), 64'd1);
        check_eq("fill_head_pc", 64'(pc0_out), 64'h1000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 2);

        // Overflow at 15 stores one entry and sets the sticky flag.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 2, 0);
        step(1'b1, 1'b0, 1, 0);
        check_eq("ovf_pre", 64'(ovf_out), 64'd0);
        step(1'b1, 1'b0, 2, 0);
        check_eq("ovf_count", 64'(count_out), 64'd16);
        check_eq("ovf_set", 64'(ovf_out), 64'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 3);
        check_eq("ovf_sticky", 64'(ovf_out), 64'd1);

        // Over-pop truncated while a pair is pushed.
        do_reset();
        step(1'b1, 1'b0, 1, 0);
        saved_pc = next_pc;
        step(1'b1, 1'b0, 2, 2);
        check_eq("trunc_count", 64'(count_out), 64'd2);
        check_eq("trunc_head", 64'(pc0_out), 64'(saved_pc));

        // Steady single push/pop across pointer wrap.
        step(1'b1, 1'b0, 1, 0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1, 1);
            check_eq("wrap_count", 64'(count_out), 64'd3);
        end

        // Flush against a stalled cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2, 0);
        step(1'b1, 1'b0, 1, 0);
        step(1'b0, 1'b1, 2, 0);
        check_eq("stall_count", 64'(count_out), 64'd9);
        step(1'b1, 1'b1, 2, 0);
        check_eq("flush_count", 64'(count_out), 64'd0);
        check_eq("flush_vld0", 64'(vld0_out), 64'd0);

`ifdef IQ_BYPASS_EN
        do_reset();
        next_pc = 32'h100;
        drive(1'b1, 1'b0, 2, 1);
        #4;
        check_eq("byp_vld0_now", 64'(vld0_out), 64'd1);
        check_eq("byp_pc0_now", 64'(pc0_out), 64'h100);
        model_update();
        @(posedge clk_in);
        #1;
        check_eq("byp_count_next", 64'(count_out), 64'd1);
        check_eq("byp_pc0_next", 64'(pc0_out), 64'h104);
`endif

        // Random traffic with an asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                do_reset();
                check_eq("midrst_count", 64'(count_out), 64'd0);
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
